// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipe scheduler
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    STOPPED = 2'd3
  } sched_state_t;

  localparam int         DISPLAY_COLS = 16;
  // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0]
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] SCORE_MAX    = 8'd255;

endpackage

// File: rtl/pipe_scheduler_if.sv
// rtl/pipe_scheduler_if.sv - control/column bus between game logic and the pipe scheduler
interface pipe_scheduler_if;

  logic                                 start;
  logic                                 pause;
  logic                                 tick;
  logic                                 game_over;
  logic                                 col_strobe;
  logic                                 col_is_pipe;
  logic [1:0]                           gap_width;
  logic [1:0]                           gap_offset;
  logic [pipe_pkg::DISPLAY_COLS-1:0]    pipe_map;
  logic [7:0]                           score;
  logic                                 running;

  modport master (
    output start, pause, tick, game_over,
    input  col_strobe, col_is_pipe, gap_width, gap_offset, pipe_map, score, running
  );

  modport slave (
    input  start, pause, tick, game_over,
    output col_strobe, col_is_pipe, gap_width, gap_offset, pipe_map, score, running
  );

endinterface

// File: rtl/pipe_lfsr.sv
// rtl/pipe_lfsr.sv - 8-bit Fibonacci LFSR (taps 8,6,5,4) with enable
module pipe_lfsr
  import pipe_pkg::*;
#(
  parameter logic [7:0] SEED   = 8'hA5,
  parameter int         Q_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [Q_BITS-1:0] q
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = {q_q[6:0], ^(q_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= SEED;
    else       q_q <= q_d;
  end

  // Callers may tap only the low bits they consume
  assign q = q_q[Q_BITS-1:0];

endmodule

// File: rtl/pipe_scheduler.sv
// rtl/pipe_scheduler.sv - emits playfield columns, tracks pipes and score
// Optional: PIPE_SCHED_DIFFICULTY_EN shrinks pipe spacing as score grows.
module pipe_scheduler
  import pipe_pkg::*;
#(
  parameter int         PIPE_SPACING = 4,
  parameter int         MIN_SPACING  = 2,
  parameter int         BIRD_COL     = 3,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  pipe_scheduler_if.slave  bus
);

  sched_state_t            state_q, state_d;
  logic                    col_strobe_q, col_strobe_d;
  logic                    col_is_pipe_q, col_is_pipe_d;
  logic [1:0]              gap_width_q, gap_width_d;
  logic [1:0]              gap_offset_q, gap_offset_d;
  logic [DISPLAY_COLS-1:0] pipe_map_q, pipe_map_d;
  logic [7:0]              score_q, score_d;
  logic [3:0]              space_cnt_q, space_cnt_d;
  logic [3:0]              spacing;
  logic [3:0]              lfsr_lo;

  pipe_lfsr #(.SEED(LFSR_SEED), .Q_BITS(4)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .q     (lfsr_lo)
  );

  always_comb begin
    spacing = 4'(PIPE_SPACING);
`ifdef PIPE_SCHED_DIFFICULTY_EN
    if (8'(score_q[7:3]) + 8'(MIN_SPACING) >= 8'(PIPE_SPACING)) spacing = 4'(MIN_SPACING);
    else spacing = 4'(PIPE_SPACING) - 4'(score_q[7:3]);
`endif
  end

  always_comb begin
    state_d       = state_q;
    col_strobe_d  = 1'b0;
    col_is_pipe_d = 1'b0;
    gap_width_d   = gap_width_q;
    gap_offset_d  = gap_offset_q;
    pipe_map_d    = pipe_map_q;
    score_d       = score_q;
    space_cnt_d   = space_cnt_q;
    case (state_q)
      IDLE, STOPPED: begin
        // A fresh game always starts at base spacing since score is cleared
        if (bus.start) begin
          state_d     = RUN;
          pipe_map_d  = '0;
          score_d     = '0;
          space_cnt_d = 4'(PIPE_SPACING - 1);
        end
      end
      RUN: begin
        if (bus.game_over)  state_d = STOPPED;
        else if (bus.pause) state_d = PAUSED;
        else if (bus.tick) begin
          col_strobe_d = 1'b1;
          if (space_cnt_q == 4'd0) begin
            col_is_pipe_d = 1'b1;
            gap_width_d   = lfsr_lo[1:0];
            gap_offset_d  = lfsr_lo[3:2];
            space_cnt_d   = spacing - 4'd1;
          end else begin
            space_cnt_d   = space_cnt_q - 4'd1;
          end
          pipe_map_d = {col_is_pipe_d, pipe_map_q[DISPLAY_COLS-1:1]};
          if (pipe_map_q[BIRD_COL] && score_q != SCORE_MAX) score_d = score_q + 8'd1;
        end
      end
      PAUSED: begin
        if (bus.game_over)  state_d = STOPPED;
        else if (!bus.pause) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      col_strobe_q  <= 1'b0;
      col_is_pipe_q <= 1'b0;
      gap_width_q   <= 2'd0;
      gap_offset_q  <= 2'd0;
      pipe_map_q    <= '0;
      score_q       <= 8'd0;
      space_cnt_q   <= 4'd0;
    end else begin
      state_q       <= state_d;
      col_strobe_q  <= col_strobe_d;
      col_is_pipe_q <= col_is_pipe_d;
      gap_width_q   <= gap_width_d;
      gap_offset_q  <= gap_offset_d;
      pipe_map_q    <= pipe_map_d;
      score_q       <= score_d;
      space_cnt_q   <= space_cnt_d;
    end
  end

  assign bus.col_strobe  = col_strobe_q;
  assign bus.col_is_pipe = col_is_pipe_q;
  assign bus.gap_width   = gap_width_q;
  assign bus.gap_offset  = gap_offset_q;
  assign bus.pipe_map    = pipe_map_q;
  assign bus.score       = score_q;
  assign bus.running     = (state_q == RUN);

endmodule
